// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// States, RV32I funct3 encodings and the idle address.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] LSU_RESET_ADDR = 32'h0100_0000;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane handling for the load/store unit.
// Extends load data and merges sub-word store data into a word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed lane and extend it
    always_comb begin
        byte_v    = rword[{addr_lo, 3'b000} +: 8];
        half_v    = addr_lo[1] ? rword[31:16] : rword[15:0];
        load_data = rword;
        unique case (1'b1)
            (funct3 == F3_B):
                load_data = {{24{byte_v[7]}}, byte_v};
            (funct3 == F3_H):
                load_data = {{16{half_v[15]}}, half_v};
            (funct3 == F3_BU):
                load_data = {24'h0, byte_v};
            (funct3 == F3_HU):
                load_data = {16'h0, half_v};
            default:
                load_data = rword;
        endcase
    end

    // Overlay the store lane onto the word read back
    always_comb begin
        store_word = wdata;
        unique case (1'b1)
            (funct3 == F3_B): begin
                store_word = rword;
                store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            (funct3 == F3_H): begin
                store_word = rword;
                store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default:
                store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit with read-modify-write for SB/SH.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = LSU_RESET_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_w_enable,
    input  logic [31:0] mem_data_out
);

    lsu_state_t  state;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rword;
    logic        err;

    logic        is_h;
    logic        is_w;
    logic        bad_f3;
    logic        acc_err;
    logic [31:0] eff_addr;
    logic [31:0] load_data;
    logic [31:0] store_word;

    // Classify the incoming request
    always_comb begin
        is_h     = (req_funct3[1:0] == 2'b01);
        is_w     = (req_funct3[1:0] == 2'b10);
        if (req_write)
            bad_f3 = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        else
            bad_f3 = (req_funct3[1:0] == 2'b11) | (req_funct3 == 3'b110);
        eff_addr = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        acc_err  = bad_f3
                 | (is_h & req_addr[0])
                 | (is_w & (req_addr[1:0] != 2'b00));
`else
        acc_err  = bad_f3;
        if (is_h)
            eff_addr[0] = 1'b0;
        if (is_w)
            eff_addr[1:0] = 2'b00;
`endif
    end

    lsu_lane_align u_align (
        .rword      (rword),
        .wdata      (wdata),
        .addr_lo    (addr[1:0]),
        .funct3     (funct3),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Request FSM and latched transaction state
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            addr   <= RESET_ADDR;
            funct3 <= 3'b000;
            write  <= 1'b0;
            wdata  <= 32'h0;
            rword  <= 32'h0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr   <= eff_addr;
                        funct3 <= req_funct3;
                        write  <= req_write;
                        wdata  <= req_wdata;
                        err    <= acc_err;
                        if (acc_err)
                            state <= S_RESP;
                        else if (req_write && req_funct3 == F3_W)
                            state <= S_WRITE;
                        else
                            state <= S_READ;
                    end
                end
                S_READ: begin
                    rword <= mem_data_out;
                    state <= write ? S_WRITE : S_RESP;
                end
                S_WRITE: state <= S_RESP;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready    = (state == S_IDLE);
    assign resp_valid   = (state == S_RESP);
    assign resp_err     = resp_valid & err;
    assign resp_rdata   = (resp_valid & ~err & ~write)
                        ? load_data : 32'h0;
    assign mem_address  = {addr[31:2], 2'b00};
    assign mem_w_enable = (state == S_WRITE);
    assign mem_data_in  = mem_w_enable ? store_word : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: vector table, random traffic
// against a byte-level memory model, and reset-during-write.
module tb_load_store_unit;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_w_enable;
    logic [31:0] mem_data_out;

    int checks   = 0;
    int failures = 0;

    logic [31:0] dmem [0:255];
    logic [7:0]  ref_mem [0:1023];
    logic        mem_hit;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_w_enable (mem_w_enable),
        .mem_data_out (mem_data_out)
    );

    assign mem_hit      = (mem_address[31:10] == BASE[31:10]);
    assign mem_data_out = mem_hit ? dmem[mem_address[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_w_enable && mem_hit)
            dmem[mem_address[9:2]] <= mem_data_in;
    end

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Behavioural model: byte memory, size/alignment arithmetic
    function automatic void ref_access(input logic wr,
                                       input logic [2:0] f3,
                                       input logic [31:0] a,
                                       input logic [31:0] wd,
                                       output logic [31:0] rd,
                                       output logic er,
                                       output int lat);
        int size;
        int off;
        logic legal;
        logic [31:0] v;
        rd = 32'h0;
        er = 1'b0;
        lat = 1;
        if (wr)
            legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else
            legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2)
                 || (f3 == 3'd4) || (f3 == 3'd5);
        if (!legal) begin
            er = 1'b1;
            return;
        end
        size = 1 << f3[1:0];
        off = int'(a - BASE);
        if (off % size != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
            er = 1'b1;
            return;
`else
            off = off - (off % size);
`endif
        end
        if (!wr) begin
            v = 32'h0;
            for (int i = 0; i < size; i++)
                v = v | (32'(ref_mem[off + i]) << (8 * i));
            if (!f3[2] && size < 4 && v[8 * size - 1])
                v = v | (32'hFFFF_FFFF << (8 * size));
            rd = v;
            lat = 2;
        end else begin
            for (int i = 0; i < size; i++)
                ref_mem[off + i] = wd[8 * i +: 8];
            lat = (size == 4) ? 2 : 3;
        end
    endfunction

    task automatic run_req(input logic wr,
                           input logic [2:0] f3,
                           input logic [31:0] a,
                           input logic [31:0] wd,
                           output logic [31:0] rd,
                           output logic er,
                           output int lat,
                           output int nwr,
                           output int wcyc,
                           output int bad_addr);
        int w;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        rd = 32'h0;
        er = 1'b0;
        lat = -1;
        nwr = 0;
        wcyc = -1;
        bad_addr = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_w_enable) begin
                nwr++;
                wcyc = k;
            end
            if (mem_address[1:0] != 2'b00)
                bad_addr++;
            if (resp_valid) begin
                lat = k;
                rd  = resp_rdata;
                er  = resp_err;
                break;
            end
        end
    endtask

    task automatic apply(input string name,
                         input logic wr,
                         input logic [2:0] f3,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         input logic [31:0] exp_rd,
                         input logic exp_er,
                         input int exp_lat);
        logic [31:0] rd;
        logic er;
        int lat, nwr, wcyc, bad;
        int exp_nwr;
        run_req(wr, f3, a, wd, rd, er, lat, nwr, wcyc, bad);
        exp_nwr = (wr && !exp_er) ? 1 : 0;
        check({name, ".rdata"}, rd, exp_rd);
        check({name, ".err"}, 32'(er), 32'(exp_er));
        check({name, ".lat"}, lat, exp_lat);
        check({name, ".wr_cnt"}, nwr, exp_nwr);
        check({name, ".wr_cyc"}, wcyc,
              exp_nwr != 0 ? exp_lat - 1 : -1);
        check({name, ".addr_al"}, bad, 0);
    endtask

    typedef struct {
        string       name;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string n, input logic wr,
                                input logic [2:0] f3,
                                input logic [31:0] a,
                                input logic [31:0] wd,
                                input logic [31:0] rd,
                                input logic er, input int lat);
        vec_t v;
        v.name = n; v.wr = wr; v.f3 = f3; v.a = a;
        v.wd = wd; v.rd = rd; v.er = er; v.lat = lat;
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m_rd;
        logic m_er;
        int m_lat;
        int bad_words;
        int rv_seen;
        logic [31:0] wv;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h0;
        dmem[4] = 32'h80FF_7F01;
        ref_mem[16] = 8'h01; ref_mem[17] = 8'h7F;
        ref_mem[18] = 8'hFF; ref_mem[19] = 8'h80;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.rvalid", 32'(resp_valid), 32'd0);
        check("rst.rdata", resp_rdata, 32'h0);
        check("rst.err", 32'(resp_err), 32'd0);
        check("rst.we", 32'(mem_w_enable), 32'd0);
        check("rst.wdata", mem_data_in, 32'h0);
        check("rst.addr", mem_address, BASE);
        reset = 1'b0;

        add("lb13", 0, 3'd0, BASE + 32'h13, 0, 32'hFFFF_FF80, 0, 2);
        add("lbu13", 0, 3'd4, BASE + 32'h13, 0, 32'h0000_0080, 0, 2);
        add("lh12", 0, 3'd1, BASE + 32'h12, 0, 32'hFFFF_80FF, 0, 2);
        add("lw10", 0, 3'd2, BASE + 32'h10, 0, 32'h80FF_7F01, 0, 2);
        add("lhu10", 0, 3'd5, BASE + 32'h10, 0, 32'h0000_7F01, 0, 2);
        add("sw10", 1, 3'd2, BASE + 32'h10, 32'h1122_3344, 0, 0, 2);
        add("sb11", 1, 3'd0, BASE + 32'h11, 32'h0000_00AA, 0, 0, 3);
        add("lw10b", 0, 3'd2, BASE + 32'h10, 0, 32'h1122_AA44, 0, 2);
        add("sh12", 1, 3'd1, BASE + 32'h12, 32'h0000_BEEF, 0, 0, 3);
        add("lw10c", 0, 3'd2, BASE + 32'h10, 0, 32'hBEEF_AA44, 0, 2);
        add("sw20", 1, 3'd2, BASE + 32'h20, 32'hDEAD_BEEF, 0, 0, 2);
        add("lw20", 0, 3'd2, BASE + 32'h20, 0, 32'hDEAD_BEEF, 0, 2);
        add("ld011", 0, 3'd3, BASE + 32'h10, 0, 32'h0, 1, 1);
        add("st100", 1, 3'd4, BASE + 32'h10, 32'hFFFF_FFFF, 0, 1, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        add("lw12", 0, 3'd2, BASE + 32'h12, 0, 32'h0, 1, 1);
        add("lh13", 0, 3'd1, BASE + 32'h13, 0, 32'h0, 1, 1);
        add("sh11", 1, 3'd1, BASE + 32'h11, 32'h1234, 0, 1, 1);
        add("lw10d", 0, 3'd2, BASE + 32'h10, 0, 32'hBEEF_AA44, 0, 2);
`else
        add("lw12", 0, 3'd2, BASE + 32'h12, 0, 32'hBEEF_AA44, 0, 2);
        add("lh13", 0, 3'd1, BASE + 32'h13, 0, 32'hFFFF_BEEF, 0, 2);
        add("sh11", 1, 3'd1, BASE + 32'h11, 32'h1234, 0, 0, 3);
        add("lw10d", 0, 3'd2, BASE + 32'h10, 0, 32'hBEEF_1234, 0, 2);
`endif

        foreach (vecs[i]) begin
            ref_access(vecs[i].wr, vecs[i].f3, vecs[i].a,
                       vecs[i].wd, m_rd, m_er, m_lat);
            apply(vecs[i].name, vecs[i].wr, vecs[i].f3, vecs[i].a,
                  vecs[i].wd, vecs[i].rd, vecs[i].er, vecs[i].lat);
        end

        for (int n = 0; n < 300; n++) begin
            logic        wr;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] wd;
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = BASE + 32'($urandom_range(0, 255));
            wd = $urandom;
            ref_access(wr, f3, a, wd, m_rd, m_er, m_lat);
            apply($sformatf("rnd%0d", n), wr, f3, a, wd,
                  m_rd, m_er, m_lat);
        end

        // SW with reset asserted during its WRITE cycle
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = BASE + 32'h30;
        req_wdata  = 32'h55AA_55AA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rstw.we", 32'(mem_w_enable), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rstw.ready", 32'(req_ready), 32'd1);
        check("rstw.rvalid", 32'(resp_valid), 32'd0);
        check("rstw.addr", mem_address, BASE);
        check("rstw.mem", dmem[12], 32'h55AA_55AA);
        rv_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid || mem_w_enable) rv_seen++;
        end
        check("rstw.quiet", rv_seen, 0);
        ref_access(1'b1, 3'd2, BASE + 32'h30, 32'h55AA_55AA,
                   m_rd, m_er, m_lat);
        apply("lw30", 0, 3'd2, BASE + 32'h30, 0,
              32'h55AA_55AA, 0, 2);

        bad_words = 0;
        for (int w = 0; w < 256; w++) begin
            wv = {ref_mem[4*w+3], ref_mem[4*w+2],
                  ref_mem[4*w+1], ref_mem[4*w]};
            if (dmem[w] !== wv) bad_words++;
        end
        check("mem.final", bad_words, 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
